// File: rtl/rca_pkg.sv
// rca_pkg: shared width constants for the ripple-carry adder slice.
//   RCA_DEFAULT_WIDTH - default operand/sum width
//   RCA_MAX_WIDTH     - largest supported operand/sum width
package rca_pkg;
    localparam int RCA_DEFAULT_WIDTH = 4;
    localparam int RCA_MAX_WIDTH     = 32;
endpackage

// File: rtl/ripple_carry_adder_if.sv
// ripple_carry_adder_if: operand/result bundle for ripple_carry_adder.
//   in_valid, A, B, Ci  - operand side (driven by master)
//   S, Co, out_valid    - registered result side (driven by slave)
//   OV                  - two's-complement overflow, present only with RCA_OVERFLOW_EN
interface ripple_carry_adder_if import rca_pkg::*; #(parameter int WIDTH = RCA_DEFAULT_WIDTH);
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Ci;
    logic [WIDTH-1:0] S;
    logic             Co;
    logic             out_valid;
`ifdef RCA_OVERFLOW_EN
    logic             OV;
    modport master (output in_valid, A, B, Ci, input S, Co, out_valid, OV);
    modport slave  (input in_valid, A, B, Ci, output S, Co, out_valid, OV);
`else
    modport master (output in_valid, A, B, Ci, input S, Co, out_valid);
    modport slave  (input in_valid, A, B, Ci, output S, Co, out_valid);
`endif
endinterface

// File: rtl/ripple_carry_adder_full_adder.sv
// full_adder: single-bit combinational full adder.
//   a, b, ci - addend bits and carry-in
//   s, co    - sum bit and carry-out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: WIDTH-bit ripple-carry adder with a one-cycle registered result.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears S, Co, out_valid (and OV)
//   bus   - ripple_carry_adder_if slave: in_valid/A/B/Ci in, S/Co/out_valid out
//   Optional: define RCA_OVERFLOW_EN to add the registered overflow flag bus.OV.
module ripple_carry_adder import rca_pkg::*; #(
    parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
    input logic                clk,
    input logic                rst_n,
    ripple_carry_adder_if.slave bus
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] s_q;
    logic             co_q;
    logic             v_q;

    assign c[0] = bus.Ci;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a  (bus.A[i]),
            .b  (bus.B[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q  <= '0;
            co_q <= 1'b0;
            v_q  <= 1'b0;
        end else begin
            v_q <= bus.in_valid;
            if (bus.in_valid) begin
                s_q  <= sum;
                co_q <= c[WIDTH];
            end
        end
    end

    assign bus.S         = s_q;
    assign bus.Co        = co_q;
    assign bus.out_valid = v_q;

`ifdef RCA_OVERFLOW_EN
    logic ov_q;

    // Overflow: carry into the sign bit differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ov_q <= 1'b0;
        else if (bus.in_valid)
            ov_q <= c[WIDTH] ^ c[WIDTH-1];
    end

    assign bus.OV = ov_q;
`endif
endmodule

// File: tb/tb_ripple_carry_adder.sv
// tb_ripple_carry_adder: scoreboard bench for ripple_carry_adder at WIDTH 4, 1 and 16.
module tb_ripple_carry_adder;
    typedef struct {
        logic [16:0] sum;
        logic        ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic done_req = 1'b0;
    logic done_seen = 1'b0;
    exp_t q[3][$];
    exp_t last[3];

    always #5 clk = ~clk;

    ripple_carry_adder_if #(.WIDTH(4))  i4 ();
    ripple_carry_adder_if #(.WIDTH(1))  i1 ();
    ripple_carry_adder_if #(.WIDTH(16)) i16 ();

    ripple_carry_adder #(.WIDTH(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(i4));
    ripple_carry_adder #(.WIDTH(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(i1));
    ripple_carry_adder #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(i16));

    // Reference: plain integer addition, overflow from signed range.
    function automatic exp_t model(input int w, input longint a, input longint b, input longint ci);
        exp_t   e;
        longint t = a + b + ci;
        longint half = longint'(1) << (w - 1);
        longint sa = (a >= half) ? a - 2 * half : a;
        longint sb = (b >= half) ? b - 2 * half : b;
        longint st = sa + sb + ci;
        e.sum = 17'(t % (4 * half));
        e.ov  = (st >= half) || (st < -half);
        return e;
    endfunction

    task automatic chk(input int ch, input logic v, input logic [16:0] got, input logic gov);
        exp_t e;
        logic ok;
        n_cmp++;
        if (!rst_n) begin
            q[ch].delete();
            last[ch].sum = '0;
            last[ch].ov  = 1'b0;
            if (v || got != 0 || gov) begin
                n_fail++;
                $display("FAIL reset ch%0d: got valid=%0b sum=%0h ov=%0b, need all 0", ch, v, got, gov);
            end
        end else if (v) begin
            if (q[ch].size() == 0) begin
                n_fail++;
                $display("FAIL spurious ch%0d: out_valid with no pending result, sum=%0h", ch, got);
            end else begin
                e = q[ch].pop_front();
                last[ch] = e;
                ok = (got === e.sum);
`ifdef RCA_OVERFLOW_EN
                ok = ok && (gov === e.ov);
`endif
                if (!ok) begin
                    n_fail++;
                    $display("FAIL result ch%0d: got {Co,S}=%0h ov=%0b, need %0h ov=%0b", ch, got, gov, e.sum, e.ov);
                end
            end
        end else if (got !== last[ch].sum) begin
            n_fail++;
            $display("FAIL hold ch%0d: got {Co,S}=%0h, need %0h", ch, got, last[ch].sum);
        end
    endtask

    always @(negedge clk) begin
        logic o4, o1, o16;
`ifdef RCA_OVERFLOW_EN
        o4 = i4.OV; o1 = i1.OV; o16 = i16.OV;
`else
        o4 = 1'b0; o1 = 1'b0; o16 = 1'b0;
`endif
        chk(0, i4.out_valid,  {12'b0, i4.Co, i4.S}, o4);
        chk(1, i1.out_valid,  {15'b0, i1.Co, i1.S}, o1);
        chk(2, i16.out_valid, {i16.Co, i16.S},      o16);
        if (done_req && !done_seen) begin
            done_seen = 1'b1;
            for (int c = 0; c < 3; c++) begin
                n_cmp++;
                if (q[c].size() != 0) begin
                    n_fail++;
                    $display("FAIL drain ch%0d: got %0d results never presented, need 0", c, q[c].size());
                end
            end
        end
    end

    // One cycle of stimulus; W1/W16 get random traffic alongside the W4 operands.
    task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b, input logic ci);
        logic        v1, v16, a1, b1, c1, c16;
        logic [15:0] a16, b16;
        @(posedge clk);
        #1;
        v1 = 1'($urandom_range(0, 3) != 0); a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
        v16 = 1'($urandom_range(0, 3) != 0); a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
        i4.in_valid = v;   i4.A = a;     i4.B = b;     i4.Ci = ci;
        i1.in_valid = v1;  i1.A = a1;    i1.B = b1;    i1.Ci = c1;
        i16.in_valid = v16; i16.A = a16; i16.B = b16;  i16.Ci = c16;
        if (rst_n) begin
            if (v)   q[0].push_back(model(4, a, b, ci));
            if (v1)  q[1].push_back(model(1, a1, b1, c1));
            if (v16) q[2].push_back(model(16, a16, b16, c16));
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        i4.in_valid = 1'b0; i1.in_valid = 1'b0; i16.in_valid = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    initial begin
        i4.in_valid = 1'b0; i4.A = '0; i4.B = '0; i4.Ci = 1'b0;
        i1.in_valid = 1'b0; i1.A = '0; i1.B = '0; i1.Ci = 1'b0;
        i16.in_valid = 1'b0; i16.A = '0; i16.B = '0; i16.Ci = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) step(1'b1, 4'hF, 4'hF, 1'b1);
        release_reset();
        step(1'b1, 4'd3, 4'd5, 1'b0);
        step(1'b1, 4'hF, 4'h0, 1'b1);
        step(1'b1, 4'hF, 4'hF, 1'b1);
        step(1'b1, 4'h7, 4'h1, 1'b0);
        step(1'b1, 4'h8, 4'h8, 1'b0);
        step(1'b1, 4'd1, 4'd1, 1'b0);
        step(1'b1, 4'd2, 4'd2, 1'b0);
        step(1'b1, 4'd7, 4'd7, 1'b0);
        repeat (3) step(1'b0, 4'hA, 4'h5, 1'b1);
        for (int x = 0; x < 512; x++) step(1'b1, 4'(x), 4'(x >> 4), x[8]);
        step(1'b0, 4'h0, 4'h0, 1'b0);
        // Result in flight when reset hits must be discarded; reset must act mid-cycle.
        step(1'b1, 4'h9, 4'h9, 1'b1);
        step(1'b1, 4'hC, 4'h6, 1'b0);
        #2 rst_n = 1'b0;
        repeat (2) step(1'b1, 4'hF, 4'hF, 1'b1);
        release_reset();
        repeat (2) step(1'b0, 4'h3, 4'h3, 1'b0);
        for (int k = 0; k < 300; k++)
            step(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 1'($urandom));
        @(posedge clk);
        #1;
        i4.in_valid = 1'b0; i1.in_valid = 1'b0; i16.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        done_req = 1'b1;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ripple_carry_adder.md
RIPPLE_CARRY_ADDER -- requirements
Module: ripple_carry_adder

Interface
REQ-001 Parameter: WIDTH, 4, operand/sum bit width (legal range 1..32).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port: clk  input  1  rising-edge clock, sole clock of the block.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: in_valid  input  1  operands valid this cycle.
REQ-006 Port: A  input  WIDTH  unsigned operand A.
REQ-007 Port: B  input  WIDTH  unsigned operand B.
REQ-008 Port: Ci  input  1  carry-in.
REQ-009 Port: S  output  WIDTH  registered sum, A+B+Ci modulo 2^WIDTH.
REQ-010 Port: Co  output  1  registered carry-out, bit WIDTH of A+B+Ci.
REQ-011 Port: out_valid  output  1  S/Co hold a new result this cycle.

Function
REQ-012 Sum SHALL be formed combinationally by a chain of WIDTH full adders: bit i takes A[i], B[i] and the carry from bit i-1; bit 0 takes Ci.
REQ-013 The full-adder chain SHALL NOT use a behavioural vector "+" operator.
REQ-014 On each rising clk with in_valid=1, S and Co SHALL capture the chain result; latency exactly 1 cycle.
REQ-015 out_valid SHALL equal in_valid delayed one cycle.
REQ-016 With in_valid=0, S and Co SHALL hold their previous values.
REQ-017 No backpressure: a new operand set SHALL be accepted every cycle in_valid=1 (throughput 1/cycle).
REQ-018 Wrap-around: all-ones + 1 SHALL give S=0, Co=1; no saturation.
REQ-019 Narrower operands driven by the instantiating module SHALL be zero-extended by the caller; the block SHALL NOT sign-extend.

Reset
REQ-020 rst_n low SHALL immediately (asynchronously) force S=0, Co=0, out_valid=0, and any optional flag to 0.
REQ-021 Reset asserted mid-operation SHALL discard the in-flight result; first out_valid after release SHALL come one cycle after the first sampled in_valid=1.
REQ-022 Reset release SHALL be synchronous to clk in effect (no capture on the releasing edge if rst_n is still low at that edge).

Configuration
REQ-023 Macro RCA_OVERFLOW_EN: when defined, the block SHALL add output port OV (1 bit, registered with S) = carry into MSB XOR carry out of MSB (two's-complement overflow).
REQ-024 Without RCA_OVERFLOW_EN, the OV port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-025 Shared package rca_pkg SHALL hold RCA_DEFAULT_WIDTH (=4) and RCA_MAX_WIDTH (=32); the WIDTH default SHALL reference RCA_DEFAULT_WIDTH.
REQ-026 One sub-module full_adder (inputs a, b, ci; outputs s, co; purely combinational) SHALL be instantiated WIDTH times via a generate loop.
REQ-027 Output registers SHALL live in ripple_carry_adder only; full_adder SHALL contain no state.

Verification
REQ-028 Reset: rst_n=0 with A=4'hF, B=4'hF, in_valid=1 -> S=0, Co=0, out_valid=0 throughout reset.
REQ-029 Basic (WIDTH=4): A=4'd3, B=4'd5, Ci=0, in_valid=1 -> next cycle S=4'd8, Co=0, out_valid=1.
REQ-030 Wrap: A=4'hF, B=4'h0, Ci=1 -> S=4'h0, Co=1; A=4'hF, B=4'hF, Ci=1 -> S=4'hF, Co=1.
REQ-031 Hold/stream: back-to-back in_valid=1 for (1,1),(2,2),(7,7) then in_valid=0 -> S=2,4,14 on consecutive cycles, then S holds 14, out_valid drops to 0.
REQ-032 Overflow (RCA_OVERFLOW_EN defined): A=4'h7, B=4'h1, Ci=0 -> S=4'h8, Co=0, OV=1; A=4'h8, B=4'h8 -> S=0, Co=1, OV=1.
REQ-033 Exhaustive WIDTH=4: all 512 (A,B,Ci) combinations -> {Co,S} equals A+B+Ci one cycle later; repeat randomized for WIDTH=1 and WIDTH=16.
